axi_dram_rd_slave: RTL and testbench
====================================

// Module: axi_dram_rd_slave
// PURPOSE
// - AXI4 read-channel responder (slave end) for one DRAM port of the CPU's *_m_inf read bus.
// - Accepts one AR request at a time. Fetches INCR burst words from a synchronous SRAM-style backing memory. Returns R beats with RLAST.
// - Synthesizable replacement for the behavioural DRAM read model in the pattern. Instantiate once per DRAM_NUMBER lane.
// PARAMETERS
// ID_WIDTH     4    AXI ID width (ARID/RID)
// ADDR_WIDTH   32   AXI byte-address width
// DATA_WIDTH   16   AXI data width; one word per beat
// MEM_AW       12   backing-memory word-address width (depth 2**MEM_AW)
// BASE_ADDR    32'h1000  byte address mapped to memory word 0
// AR_LAT       2    idle cycles after AR handshake before first memory read (0..15)
// PORTS
// clk             in   1           rising-edge clock
// rst             in   1           asynchronous active-high reset
// arid_s_inf      in   ID_WIDTH    read address ID
// araddr_s_inf    in   ADDR_WIDTH  burst start byte address
// arlen_s_inf     in   7           beats-1 (1..128 beats)
// arsize_s_inf    in   3           must be 3'b001 (2 bytes)
// arburst_s_inf   in   2           must be 2'b01 (INCR)
// arvalid_s_inf   in   1           AR valid
// arready_s_inf   out  1           AR ready
// rid_s_inf       out  ID_WIDTH    echoed ARID
// rdata_s_inf     out  DATA_WIDTH  read data
// rresp_s_inf     out  2           2'b00 OKAY / 2'b10 SLVERR
// rlast_s_inf     out  1           final beat of burst
// rvalid_s_inf    out  1           R valid
// rready_s_inf    in   1           R ready (master back-pressure)
// mem_rd_en       out  1           backing-memory read strobe
// mem_addr        out  MEM_AW      backing-memory word address
// mem_rdata       in   DATA_WIDTH  memory data, valid 1 cycle after mem_rd_en
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, counters 0. On reset assertion mid-burst, the burst is abandoned with no further beats. The next burst is accepted only after a fresh AR.
// - FSM: IDLE -> WAIT -> BURST -> IDLE.
//   - IDLE: arready=1 (registered, asserted the cycle after entering IDLE). On arvalid&&arready, latch id, len, word address and err flag, then go to WAIT.
//   - WAIT: arready=0. Count AR_LAT cycles (AR_LAT=0 means go straight to BURST).
//   - BURST: issue reads. Return to IDLE on the cycle the last beat handshakes (rvalid&&rready&&rlast).
// - Address: word = (araddr-BASE_ADDR)>>1. Increments by 1 per beat. No 4KB-boundary wrap handling is required; the master never crosses one.
// - err flag (whole burst returns SLVERR, rdata=0, mem_rd_en suppressed) is set if any of the following hold:
//   - arsize!=3'b001;
//   - arburst!=2'b01;
//   - araddr<BASE_ADDR;
//   - araddr[0]==1;
//   - last word index > 2**MEM_AW-1.
// - Read pipeline (1-deep, full throughput):
//   - mem_rd_en = BURST && beats_issued<=len && (!rvalid || rready).
//   - The rvalid/rdata register loads mem_rdata the cycle after mem_rd_en. rvalid stays high with rdata/rlast/rresp stable while !rready. rvalid is cleared when rready is high and no read was issued in the previous cycle.
// - With rready held high, beats occur on consecutive cycles. The first rvalid comes AR_LAT+2 cycles after the AR handshake cycle.
// - rlast=1 only on beat number len (0-based). rid is constant for the burst.
// - arvalid while busy: ignored (arready=0). The master must hold the request until it is accepted.
// - arlen=0: single beat with rlast=1.
// - Counters: beats_issued and beats_sent are 8-bit, so 128 beats cause no overflow.
// STRUCTURE
// - Shared package axi_pkg: constants for RESP_OKAY/RESP_SLVERR, BURST_INCR, SIZE_2B, and the FSM state enum {IDLE,WAIT,BURST}.
// - Single module. No sub-module; the backing SRAM is external and connected via the mem_* ports.
// TESTING
// 1. Reset -> arready=0 during reset, 1 one cycle after release; rvalid=0, rresp=0.
// 2. AR id=4'h3, addr=32'h1000, len=7, rready=1, mem[i]=i+16'hA000 -> 8 beats on consecutive cycles with data A000..A007, rid=3, rlast only on the 8th, rresp=0.
// 3. Same burst with rready toggled 1,0,0,1,... -> no beat lost or duplicated; rdata is stable while stalled; the sequence is still A000..A007.
// 4. len=127 at addr=32'h1000 -> 128 beats; rlast on beat 127; arready returns 1 the cycle after the last handshake.
// 5. addr=32'h1001 or arsize=3'b010 with len=3 -> 4 beats with rresp=2'b10, rdata=0, mem_rd_en never asserted.
// 6. Assert rst during beat 3 of an 8-beat burst -> rvalid drops immediately. A new AR after release returns a correct fresh burst.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants and the responder FSM state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_2B     = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } axi_state_e;

endpackage

// File: rtl/axi_dram_rd_slave.sv
// AXI4 read responder for one DRAM lane: one AR at a time, INCR bursts fetched
// from an external synchronous SRAM, R beats returned with RLAST.
module axi_dram_rd_slave
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    MEM_AW     = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000,
  parameter int                    AR_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [6:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf,
  output logic                  mem_rd_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            o_dbg_state
);

  localparam logic [3:0] LAT_LAST = 4'(AR_LAT - 1);

  axi_state_e            r_state, w_state_next;
  logic                  r_arready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [6:0]            r_len;
  logic [MEM_AW-1:0]     r_addr;
  logic                  r_err;
  logic [3:0]            r_wait_cnt;
  logic [7:0]            r_issued;
  logic [7:0]            r_sent;
  logic                  r_rvalid;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_rlast;
  logic                  w_issue;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH:0]   w_last_word;

  assign w_offset    = araddr_s_inf - BASE_ADDR;
  assign w_word      = w_offset >> 1;
  assign w_last_word = {1'b0, w_word} + {{(ADDR_WIDTH-6){1'b0}}, arlen_s_inf};
  assign w_err       = (arsize_s_inf != SIZE_2B) || (arburst_s_inf != BURST_INCR) ||
                       (araddr_s_inf < BASE_ADDR) || araddr_s_inf[0] ||
                       (w_last_word[ADDR_WIDTH:MEM_AW] != '0);

  assign w_ar_hs = (r_state == IDLE) && r_arready && arvalid_s_inf;
  assign w_r_hs  = r_rvalid && rready_s_inf;
  assign w_rlast = r_rvalid && (r_sent == {1'b0, r_len});
  // A read may issue only when the single output slot is empty or drains this cycle.
  assign w_issue = (r_state == BURST) && (r_issued <= {1'b0, r_len}) &&
                   (!r_rvalid || rready_s_inf);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_ar_hs) w_state_next = (AR_LAT == 0) ? BURST : WAIT;
      WAIT:    if (r_wait_cnt == LAT_LAST) w_state_next = BURST;
      BURST:   if (w_r_hs && w_rlast) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_arready  <= 1'b0;
      r_id       <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_arready <= (w_state_next == IDLE);
      if (w_ar_hs) begin
        r_id       <= arid_s_inf;
        r_len      <= arlen_s_inf;
        r_addr     <= w_word[MEM_AW-1:0];
        r_err      <= w_err;
        r_wait_cnt <= '0;
        r_issued   <= '0;
        r_sent     <= '0;
      end
      if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
      if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_issued <= r_issued + 8'd1;
      end
      if (w_r_hs) r_sent <= r_sent + 8'd1;
      if (w_issue) r_rvalid <= 1'b1;
      else if (rready_s_inf) r_rvalid <= 1'b0;
    end
  end

  // The SRAM output register is the R data stage: it holds while no read is issued.
  assign rdata_s_inf   = (r_rvalid && !r_err) ? mem_rdata : '0;
  assign rresp_s_inf   = (r_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign rlast_s_inf   = w_rlast;
  assign rvalid_s_inf  = r_rvalid;
  assign rid_s_inf     = r_id;
  assign arready_s_inf = r_arready;
  assign mem_rd_en     = w_issue && !r_err;
  assign mem_addr      = r_addr;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axi_dram_rd_slave.sv
// Directed bench for axi_dram_rd_slave: AR driver, SRAM model, R-channel scoreboard.
module tb_axi_dram_rd_slave;

  localparam int AR_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [6:0]  arlen = '0;
  logic [2:0]  arsize = 3'b001;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [15:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_q = '0;
  logic [1:0]  dbg_state;

  logic [15:0] mem [0:4095];
  logic [22:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rr_mode = 0;
  int rr_idx = 0;
  int beat_cnt = 0;
  int rd_en_cnt = 0;
  int prev_cyc = 0;
  bit first_beat = 1'b1;
  bit stall_pending = 1'b0;
  logic [22:0] stall_val = '0;

  axi_dram_rd_slave #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .MEM_AW(12),
    .BASE_ADDR(32'h1000), .AR_LAT(AR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen),
    .arsize_s_inf(arsize), .arburst_s_inf(arburst),
    .arvalid_s_inf(arvalid), .arready_s_inf(arready),
    .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp),
    .rlast_s_inf(rlast), .rvalid_s_inf(rvalid), .rready_s_inf(rready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_q),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset-independent infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 + 16'(i);
  always @(posedge clk) if (mem_rd_en) mem_q <= mem[mem_addr];

  function automatic logic [22:0] pack(input logic [3:0] id, input logic [1:0] resp,
                                       input logic last, input logic [15:0] data);
    return {id, resp, last, data};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // R-ready pattern driver: mode 0 = always ready, mode 1 = 1,0,0,1 repeating
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 1) begin
        rready = ((rr_idx % 4) == 0) || ((rr_idx % 4) == 3);
        rr_idx++;
      end else begin
        rready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
      first_beat = 1'b1;
    end else begin
      if (mem_rd_en) rd_en_cnt++;
      if (stall_pending) begin
        chk("stall_valid_held", 32'(rvalid), 32'd1);
        chk("stall_beat_stable", 32'(pack(rid, rresp, rlast, rdata)), 32'(stall_val));
      end
      stall_pending = 1'b0;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected none", pack(rid, rresp, rlast, rdata));
        end else begin
          chk("r_beat", 32'(pack(rid, rresp, rlast, rdata)), 32'(exp_q.pop_front()));
        end
        if (rr_mode == 0 && !first_beat) chk("b2b_gap", 32'(cyc - prev_cyc), 32'd1);
        prev_cyc = cyc;
        first_beat = rlast;
        beat_cnt++;
      end else if (rvalid) begin
        stall_pending = 1'b1;
        stall_val = pack(rid, rresp, rlast, rdata);
      end
    end
  end

  task automatic push_burst(input logic [3:0] id, input int word, input int len, input bit err);
    for (int i = 0; i <= len; i++)
      exp_q.push_back(pack(id, err ? 2'b10 : 2'b00, (i == len),
                           err ? 16'h0 : 16'hA000 + 16'(word + i)));
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [6:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      arvalid = 1'b0;
      $display("FAIL ar_accept: got arready=0 expected 1 within 300 cycles");
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit seen;
    // 1: reset values
    repeat (2) @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arready_before_edge", 32'(arready), 32'd0);
    @(negedge clk);
    chk("arready_after_release", 32'(arready), 32'd1);

    // 2: 8-beat burst, rready high, first-beat latency
    rr_mode = 0;
    push_burst(4'h3, 0, 7, 1'b0);
    send_ar(4'h3, 32'h1000, 7'd7, 3'b001, 2'b01);
    repeat (AR_LAT) @(posedge clk);
    @(negedge clk);
    chk("lat_first_rd_en", 32'(mem_rd_en), 32'd1);
    chk("lat_rvalid_low", 32'(rvalid), 32'd0);
    chk("busy_arready_low", 32'(arready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_rvalid_high", 32'(rvalid), 32'd1);
    wait_drain(100);

    // 3: same burst with back-pressure
    rr_idx = 0;
    rr_mode = 1;
    push_burst(4'h3, 0, 7, 1'b0);
    send_ar(4'h3, 32'h1000, 7'd7, 3'b001, 2'b01);
    wait_drain(200);
    rr_mode = 0;
    repeat (2) @(negedge clk);

    // 4: 128-beat burst, arready returns after last handshake
    push_burst(4'h9, 0, 127, 1'b0);
    send_ar(4'h9, 32'h1000, 7'd127, 3'b001, 2'b01);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (rvalid && rready && rlast) seen = 1'b1;
    end
    chk("long_last_seen", 32'(seen), 32'd1);
    chk("long_arready_at_last", 32'(arready), 32'd0);
    @(negedge clk);
    chk("long_arready_after_last", 32'(arready), 32'd1);
    wait_drain(50);

    // 5: error bursts (odd addr, bad size, below base, past end), then top-word single beat
    rd_en_cnt = 0;
    push_burst(4'h1, 0, 3, 1'b1);
    send_ar(4'h1, 32'h1001, 7'd3, 3'b001, 2'b01);
    wait_drain(100);
    push_burst(4'h2, 0, 3, 1'b1);
    send_ar(4'h2, 32'h1000, 7'd3, 3'b010, 2'b01);
    wait_drain(100);
    push_burst(4'h4, 0, 0, 1'b1);
    send_ar(4'h4, 32'h0FFE, 7'd0, 3'b001, 2'b01);
    wait_drain(100);
    push_burst(4'h5, 0, 1, 1'b1);
    send_ar(4'h5, 32'h2FFE, 7'd1, 3'b001, 2'b01);
    wait_drain(100);
    chk("err_no_mem_rd_en", 32'(rd_en_cnt), 32'd0);
    push_burst(4'h7, 4095, 0, 1'b0);
    send_ar(4'h7, 32'h2FFE, 7'd0, 3'b001, 2'b01);
    wait_drain(100);

    // 6: reset during beat 3, then a fresh burst
    beat_cnt = 0;
    push_burst(4'h5, 0, 7, 1'b0);
    send_ar(4'h5, 32'h1000, 7'd7, 3'b001, 2'b01);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      #2;
      if (beat_cnt >= 3) seen = 1'b1;
    end
    chk("midburst_reached_beat3", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    chk("midburst_rvalid_drop", 32'(rvalid), 32'd0);
    chk("midburst_arready_low", 32'(arready), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_no_beats", 32'(rvalid), 32'd0);
    push_burst(4'h6, 8, 3, 1'b0);
    send_ar(4'h6, 32'h1010, 7'd3, 3'b001, 2'b01);
    wait_drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
